// File: rtl/pool_window_buffer.sv
// pool_window_buffer: gathers raster-order pixels into non-overlapping POOL_DIM x POOL_DIM windows
// and emits each completed window as one packed vector, top-left element in the LSBs.
module pool_window_buffer #(
  parameter int NN_WIDTH  = 32,
  parameter int POOL_DIM  = 2,
  parameter int FM_WIDTH  = 8,
  parameter int FM_HEIGHT = 8
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NN_WIDTH-1:0]                      pixel_in,
  input  logic                                     pixel_valid,
  input  logic                                     frame_restart,
  output logic [NN_WIDTH*POOL_DIM*POOL_DIM-1:0]    window_out,
  output logic                                     window_valid,
  output logic                                     frame_done
);
  localparam int NS = POOL_DIM * POOL_DIM;
  localparam int WW = NN_WIDTH * NS;
  localparam int CW = FM_WIDTH > 1 ? $clog2(FM_WIDTH) : 1;
  localparam int RW = FM_HEIGHT > 1 ? $clog2(FM_HEIGHT) : 1;
  localparam int PW = $clog2(POOL_DIM);
  logic [CW-1:0]       col_q, col_d, col_e, base;
  logic [RW-1:0]       row_q, row_d, row_e;
  logic [PW-1:0]       pc_q, pc_d, pc_e, pr_q, pr_d, pr_e;
  logic                last_col, last_row, last_pc, last_pr, emit, shift;
  logic [WW-1:0]       win, window_out_q, window_out_d;
  logic                window_valid_q, window_valid_d, frame_done_q, frame_done_d;
  logic [NN_WIDTH-1:0] cur_q [POOL_DIM-1];
  logic [NN_WIDTH-1:0] cur_d [POOL_DIM-1];
  // pc/pr track col%POOL_DIM and row%POOL_DIM so no divider is needed
  always_comb begin
    col_e          = frame_restart ? '0 : col_q;
    row_e          = frame_restart ? '0 : row_q;
    pc_e           = frame_restart ? '0 : pc_q;
    pr_e           = frame_restart ? '0 : pr_q;
    last_col       = col_e == CW'(FM_WIDTH - 1);
    last_row       = row_e == RW'(FM_HEIGHT - 1);
    last_pc        = pc_e == PW'(POOL_DIM - 1);
    last_pr        = pr_e == PW'(POOL_DIM - 1);
    emit           = pixel_valid && last_pr && last_pc;
    shift          = pixel_valid && last_pr;
    col_d          = pixel_valid ? (last_col ? '0 : col_e + CW'(1)) : col_e;
    pc_d           = pixel_valid ? (last_pc ? '0 : pc_e + PW'(1)) : pc_e;
    row_d          = (pixel_valid && last_col) ? (last_row ? '0 : row_e + RW'(1)) : row_e;
    pr_d           = (pixel_valid && last_col) ? (last_pr ? '0 : pr_e + PW'(1)) : pr_e;
    base           = col_e - CW'(POOL_DIM - 1);
    window_valid_d = emit;
    frame_done_d   = emit && last_row && last_col;
    window_out_d   = emit ? win : window_out_q;
  end
  for (genvar r = 0; r < POOL_DIM - 1; r++) begin : g_line
    logic [NN_WIDTH-1:0] line_buf_q [FM_WIDTH];
    logic [NN_WIDTH-1:0] line_d [FM_WIDTH];
    always_comb begin
      line_d = line_buf_q;
      if (pixel_valid && pr_e == PW'(r)) line_d[col_e] = pixel_in;
    end
    always_ff @(posedge clock) line_buf_q <= line_d;
    for (genvar c = 0; c < POOL_DIM; c++) begin : g_col
      assign win[(r*POOL_DIM+c)*NN_WIDTH +: NN_WIDTH] = line_buf_q[base + CW'(c)];
    end
  end
  // last window row comes from the shift register plus the completing pixel itself
  for (genvar c = 0; c < POOL_DIM; c++) begin : g_last
    if (c == POOL_DIM - 1) begin : g_pix
      assign win[((POOL_DIM-1)*POOL_DIM+c)*NN_WIDTH +: NN_WIDTH] = pixel_in;
    end else begin : g_cur
      assign win[((POOL_DIM-1)*POOL_DIM+c)*NN_WIDTH +: NN_WIDTH] = cur_q[c];
      if (c == POOL_DIM - 2) begin : g_tail
        assign cur_d[c] = shift ? pixel_in : cur_q[c];
      end else begin : g_mid
        assign cur_d[c] = shift ? cur_q[c+1] : cur_q[c];
      end
    end
  end
  always_ff @(posedge clock) cur_q <= cur_d;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q          <= '0;
      row_q          <= '0;
      pc_q           <= '0;
      pr_q           <= '0;
      window_out_q   <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      pc_q           <= pc_d;
      pr_q           <= pr_d;
      window_out_q   <= window_out_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end
  assign window_out   = window_out_q;
  assign window_valid = window_valid_q;
  assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_pool_window_buffer.sv
// tb_pool_window_buffer: directed scenarios against a frame-array model of pooling windows,
// plus literal window values pinning the model.
module tb_pool_window_buffer;
  localparam int NN = 8;
  localparam int P  = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WB = NN * P * P;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NN-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          frame_restart = 1'b0;
  logic [WB-1:0] window_out;
  logic          window_valid;
  logic          frame_done;
  pool_window_buffer #(.NN_WIDTH(NN), .POOL_DIM(P), .FM_WIDTH(W), .FM_HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_restart(frame_restart), .window_out(window_out), .window_valid(window_valid),
    .frame_done(frame_done)
  );
  always #5 clock = ~clock;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [WB-1:0] exp_win = '0;
  logic          exp_valid = 1'b0;
  logic          exp_done = 1'b0;
  logic          exp_zero = 1'b1;
  int            mr = 0;
  int            mc = 0;
  int            fr [H][W];
  logic [WB-1:0] obs_win [$];
  logic          obs_done [$];
  logic [WB-1:0] s1 [4] = '{32'h05040100, 32'h07060302, 32'h0D0C0908, 32'h0F0E0B0A};
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    #2;
    chk("window_valid", window_valid, exp_valid);
    chk("frame_done", frame_done, exp_done);
    if (exp_valid) chk("window_out", window_out, exp_win);
    if (exp_zero) chk("window_out_in_reset", window_out, 0);
    if (window_valid) begin
      obs_win.push_back(window_out);
      obs_done.push_back(frame_done);
    end
  end
  // one cycle of stimulus; the model predicts what the outputs show after the next rising edge
  task automatic cyc(bit v, int pix, bit rs, bit rl);
    @(negedge clock);
    reset = rl;
    pixel_valid = v;
    pixel_in = NN'(pix);
    frame_restart = rs;
    exp_valid = 1'b0;
    exp_done = 1'b0;
    exp_zero = !rl;
    if (!rl) begin
      mr = 0;
      mc = 0;
    end else begin
      if (rs) begin
        mr = 0;
        mc = 0;
      end
      if (v) begin
        fr[mr][mc] = pix;
        if (mr % P == P - 1 && mc % P == P - 1) begin
          exp_valid = 1'b1;
          exp_done = (mr == H - 1) && (mc == W - 1);
          for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++)
              exp_win[(r*P+c)*NN +: NN] = NN'(fr[mr-P+1+r][mc-P+1+c]);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr + 1) % H;
        end
      end
    end
  endtask
  task automatic px(int pix);
    cyc(1'b1, pix, 1'b0, 1'b1);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b1);
  endtask
  task automatic clear_obs();
    obs_win.delete();
    obs_done.delete();
  endtask
  task automatic check_s1(string tag, int off);
    for (int k = 0; k < 4; k++) begin
      if (off + k < obs_win.size()) begin
        chk({tag, "_win"}, obs_win[off+k], s1[k]);
        chk({tag, "_done"}, obs_done[off+k], k == 3);
      end
    end
  endtask
  initial begin
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 1'b0);
    idle(1);
    clear_obs();
    for (int i = 0; i < 16; i++) px(i);
    idle(3);
    chk("s1_count", obs_win.size(), 4);
    check_s1("s1", 0);
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      px(i);
      idle($urandom_range(3));
    end
    idle(3);
    chk("s2_count", obs_win.size(), 4);
    check_s1("s2", 0);
    clear_obs();
    for (int i = 0; i < 32; i++) px(i);
    idle(3);
    chk("s3_count", obs_win.size(), 8);
    if (obs_win.size() == 8) begin
      chk("s3_first_of_second", obs_win[4], 32'h15141110);
      chk("s3_done_total", int'(obs_done[3]) + int'(obs_done[7]), 2);
    end
    clear_obs();
    for (int i = 0; i < 7; i++) px(i);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 16; i++) px(i);
    idle(3);
    chk("s4_count", obs_win.size(), 5);
    if (obs_win.size() > 0) chk("s4_pre_reset", obs_win[0], 32'h05040100);
    check_s1("s4", 1);
    clear_obs();
    for (int i = 0; i < 9; i++) px(i);
    cyc(1'b1, 0, 1'b1, 1'b1);
    for (int i = 1; i < 16; i++) px(i);
    idle(3);
    chk("s5_count", obs_win.size(), 6);
    if (obs_win.size() > 1) begin
      chk("s5_pre0", obs_win[0], 32'h05040100);
      chk("s5_pre1", obs_win[1], 32'h07060302);
    end
    check_s1("s5", 2);
    clear_obs();
    for (int i = 0; i < 20; i++) cyc(1'b0, 0, 1'b0, 1'b0);
    chk("s6_count", obs_win.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
